inst_fetch_ctrl: RTL and testbench

//  Sequences the program counter and the instruction-SRAM request channel for the MIPS fetch stage.

---
 rtl/inst_fetch_ctrl_pkg.sv | 23 ++
 rtl/inst_fetch_ctrl_npc_mux.sv | 43 ++++
 rtl/inst_fetch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
//   Shared definitions for the MIPS instruction-fetch controller:
//   - boot address (first fetch after reset)
//   - CP0 exception vector (bootstrap, BEV=1)
//   - fetch FSM state type
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

  localparam int unsigned IFC_WIDTH      = 32;
  localparam logic [31:0] IFC_RESET_PC   = 32'hBFC0_0000;
  localparam logic [31:0] IFC_EXC_VECTOR = 32'hBFC0_0380;

  // S_REQ  : request driven to the SRAM, waiting for address acceptance
  // S_WAIT : address accepted, waiting for the returned word
  // S_HOLD : returned word sits in the output buffer, waiting for decode
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_npc_mux.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_npc_mux
//   Combinational next-PC select for the fetch stage.
//   Priority: redirect (exception/ERET) > pending branch target > PC + 4.
//   The result is always word aligned; PC + 4 wraps modulo 2^WIDTH.
//
// Ports
//   i_flush        redirect request this cycle
//   i_flush_pc     redirect address
//   i_pend_use     pending branch target is due for this fetch
//   i_pend_target  pending branch target
//   i_fetch_pc     PC of the most recent fetch
//   o_npc          selected next fetch address (low 2 bits zero)
// -----------------------------------------------------------------------------
module inst_fetch_ctrl_npc_mux
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = IFC_WIDTH
) (
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_flush_pc,
  input  logic             i_pend_use,
  input  logic [WIDTH-1:0] i_pend_target,
  input  logic [WIDTH-1:0] i_fetch_pc,
  output logic [WIDTH-1:0] o_npc
);

  logic [WIDTH-1:0] w_seq_pc;
  logic [WIDTH-1:0] w_sel_pc;

  always_comb begin
    w_seq_pc = i_fetch_pc + WIDTH'(4);
    if (i_flush) begin
      w_sel_pc = i_flush_pc;
    end else if (i_pend_use) begin
      w_sel_pc = i_pend_target;
    end else begin
      w_sel_pc = w_seq_pc;
    end
    o_npc = {w_sel_pc[WIDTH-1:2], 2'b00};
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   MIPS fetch-stage sequencer. Chooses the next PC, drives the instruction
//   SRAM request channel with at most one transaction in flight, and hands
//   each fetched word to decode through a 1-entry valid/ready buffer.
//
// Parameters
//   WIDTH     address/data width
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   inst_req      SRAM request valid
//   inst_addr     SRAM request address (word aligned)
//   inst_addr_ok  SRAM accepted the address this cycle
//   inst_data_ok  SRAM returns inst_rdata this cycle
//   inst_rdata    fetched instruction word
//   br_taken      decode: taken branch/jump (1-cycle pulse)
//   br_target     branch/jump target
//   flush         CP0: exception/ERET redirect (1-cycle pulse)
//   flush_pc      redirect address
//   if_valid      fetched word available to decode
//   if_ready      decode accepts the word
//   if_pc         PC of the word on if_inst
//   if_inst       instruction word
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH    = IFC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = IFC_RESET_PC[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  output logic [WIDTH-1:0] inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [WIDTH-1:0] inst_rdata,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_inst
);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;

  logic [WIDTH-1:0] r_fetch_pc;     // address being requested / in flight / buffered
  logic             r_pend_valid;   // a taken branch target is waiting to be used
  logic             r_pend_skip;    // delay slot not yet chosen: skip one sequential step
  logic [WIDTH-1:0] r_pend_target;
  logic             r_discard;      // in-flight word was redirected away; drop it
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_pc;
  logic [WIDTH-1:0] r_out_inst;

  logic             w_consume;
  logic             w_pend_use;
  logic             w_load_npc;
  logic [WIDTH-1:0] w_npc;

  assign w_consume  = r_out_valid & if_ready;
  assign w_pend_use = r_pend_valid & ~r_pend_skip;
  // A new fetch address is chosen on redirect, or when decode takes the
  // buffered word (the only way out of S_HOLD without a redirect).
  assign w_load_npc = flush | ((r_state == S_HOLD) & w_consume);

  inst_fetch_ctrl_npc_mux #(
    .WIDTH (WIDTH)
  ) u_npc_mux (
    .i_flush       (flush),
    .i_flush_pc    (flush_pc),
    .i_pend_use    (w_pend_use),
    .i_pend_target (r_pend_target),
    .i_fetch_pc    (r_fetch_pc),
    .o_npc         (w_npc)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      // An address accepted in the same cycle as a redirect is still in
      // flight and must be drained (dropped) in S_WAIT.
      S_REQ: begin
        if (inst_addr_ok) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          w_state_nxt = (flush || r_discard) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || w_consume) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Reset state is S_REQ, so the request is qualified with resetn to keep
    // inst_req low while reset is held.
    inst_req  = resetn & (r_state == S_REQ);
    inst_addr = {r_fetch_pc[WIDTH-1:2], 2'b00};
    if_valid  = r_out_valid;
    if_pc     = r_out_pc;
    if_inst   = r_out_inst;
  end

  // ---------------------------------------------------------------------------
  // Fetch PC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_load_npc) begin
      r_fetch_pc <= w_npc;
    end
  end

  // ---------------------------------------------------------------------------
  // Discard flag: set when a redirect arrives while a word is in flight and
  // has not returned in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_discard <= 1'b0;
    end else if ((r_state == S_WAIT) && inst_data_ok) begin
      r_discard <= 1'b0;
    end else if (flush && ((r_state == S_WAIT) ||
                           ((r_state == S_REQ) && inst_addr_ok))) begin
      r_discard <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending branch target.
  // When the branch is still sitting unconsumed in the output buffer, the
  // next chosen address is the delay slot, so the target must wait one more
  // selection (r_pend_skip). Otherwise the delay slot is already chosen or in
  // flight and the target applies to the next selection.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_valid  <= 1'b0;
      r_pend_skip   <= 1'b0;
      r_pend_target <= '0;
    end else if (flush) begin
      r_pend_valid  <= 1'b0;
      r_pend_skip   <= 1'b0;
    end else if (br_taken) begin
      r_pend_valid  <= 1'b1;
      r_pend_skip   <= r_out_valid & ~if_ready;
      r_pend_target <= br_target;
    end else if ((r_state == S_HOLD) && w_consume && r_pend_valid) begin
      if (r_pend_skip) begin
        r_pend_skip  <= 1'b0;
      end else begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer (1 entry). The buffer is empty whenever a word can return,
  // so load and consume never coincide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= RESET_PC;
      r_out_inst  <= '0;
    end else if (flush || w_consume) begin
      r_out_valid <= 1'b0;
    end else if ((r_state == S_WAIT) && inst_data_ok && !r_discard) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= {r_fetch_pc[WIDTH-1:2], 2'b00};
      r_out_inst  <= inst_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch_ctrl #(
    .WIDTH    (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_consumed = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event with empty scoreboard, expected none (t=%0t)", name, $time);
  endtask

  // Instruction memory content as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Redirect/branch addresses: vector, wrap corner, or random (possibly unaligned).
  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    case ($urandom_range(3))
      0:       r = EXC_PC;
      1:       r = 32'hFFFF_FFF8;
      default: r = $urandom;
    endcase
    return r;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } word_t;

  logic [31:0] req_q[$];
  word_t       word_q[$];

  // Program-order reference: next address to be accepted, and branch progress
  // (0 idle, 1 delay slot not yet accepted, 2 target is next).
  logic [31:0] m_nxt;
  int          m_stage;
  logic [31:0] m_tgt;

  // SRAM responder state.
  bit          sram_busy;
  logic [31:0] sram_addr;

  // Stimulus knobs.
  bit          drv_en;
  int          p_aok, p_dok, p_rdy, p_flush, p_br;
  bit          force_flush_wait, force_br_hold, force_flush_br, stall_req;
  int          stall_left;
  logic [31:0] force_pc, force_tgt;

  task automatic model_reset();
    req_q.delete();
    word_q.delete();
    m_nxt   = RST_PC;
    m_stage = 0;
    m_tgt   = '0;
  endtask

  task automatic model_step(input bit aok, input bit dok, input bit fl, input bit br,
                            input logic [31:0] fpc, input logic [31:0] tgt);
    word_t w;
    if (aok) begin
      req_q.push_back(m_nxt);
      w.pc   = m_nxt;
      w.inst = mem_word(m_nxt);
      word_q.push_back(w);
      if (m_stage == 1) begin
        m_nxt   = m_tgt;
        m_stage = 2;
      end else begin
        if (m_stage == 2) m_stage = 0;
        m_nxt = m_nxt + 32'd4;
      end
      sram_busy = 1'b1;
      sram_addr = inst_addr;
    end else if (dok) begin
      sram_busy = 1'b0;
    end
    if (br) begin
      m_tgt   = {tgt[31:2], 2'b00};
      m_stage = 1;
    end
    if (fl) begin
      m_nxt   = {fpc[31:2], 2'b00};
      m_stage = 0;
      word_q.delete();
    end
  endtask

  task automatic drive_cycle();
    bit aok, dok, rdy, fl, br;
    logic [31:0] fpc, tgt;
    aok = inst_req && ($urandom_range(99) < p_aok);
    dok = sram_busy && ($urandom_range(99) < p_dok);
    rdy = $urandom_range(99) < p_rdy;
    if (stall_req && if_valid) begin
      stall_left = 6;
      stall_req  = 1'b0;
    end
    if (stall_left > 1) rdy = 1'b0;
    else if (stall_left == 1) rdy = 1'b1;
    if (stall_left > 0) stall_left--;
    fl  = $urandom_range(999) < p_flush;
    fpc = rand_pc();
    br  = if_valid && (m_stage == 0) && ($urandom_range(99) < p_br);
    tgt = rand_pc();
    if (force_flush_wait && sram_busy && !dok) begin
      fl = 1'b1; fpc = force_pc; force_flush_wait = 1'b0;
    end
    if (force_br_hold && if_valid && !rdy && (m_stage == 0)) begin
      br = 1'b1; tgt = force_tgt; fl = 1'b0; force_br_hold = 1'b0;
    end
    if (force_flush_br && if_valid && (m_stage == 0)) begin
      fl = 1'b1; br = 1'b1; fpc = force_pc; tgt = force_tgt; force_flush_br = 1'b0;
    end
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = dok ? mem_word(sram_addr) : $urandom;
    if_ready     = rdy;
    flush        = fl;
    flush_pc     = fpc;
    br_taken     = br;
    br_target    = tgt;
    model_step(aok, dok, fl, br, fpc, tgt);
  endtask

  // Driver: inputs change on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (drv_en) drive_cycle();
    end
  end

  // Monitor: observes handshakes and pops the scoreboard.
  initial begin
    bit p_hold, p_cons, p_fl;
    logic [31:0] h_pc, h_inst;
    word_t w;
    p_hold = 0; p_cons = 0; p_fl = 0; h_pc = '0; h_inst = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        p_hold = 0; p_cons = 0; p_fl = 0;
        continue;
      end
      if (p_hold) begin
        check1("hold_valid", if_valid, 1'b1);
        check32("hold_pc", if_pc, h_pc);
        check32("hold_inst", if_inst, h_inst);
      end
      if (p_cons) check1("req_after_consume", inst_req, 1'b1);
      if (p_fl)   check1("valid_after_flush", if_valid, 1'b0);
      check1("no_req_while_full", inst_req && if_valid, 1'b0);
      if (inst_req) check32("addr_align", {30'd0, inst_addr[1:0]}, 32'd0);
      if (inst_req && inst_addr_ok) begin
        if (req_q.size() == 0) fail_now("req_addr");
        else check32("req_addr", inst_addr, req_q.pop_front());
      end
      if (if_valid && if_ready && !flush) begin
        n_consumed++;
        if (word_q.size() == 0) fail_now("if_word");
        else begin
          w = word_q.pop_front();
          check32("if_pc", if_pc, w.pc);
          check32("if_inst", if_inst, w.inst);
        end
      end
      p_hold = if_valid && !if_ready && !flush;
      p_cons = if_valid && if_ready && !flush;
      p_fl   = flush;
      h_pc   = if_pc;
      h_inst = if_inst;
    end
  end

  task automatic idle_inputs();
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0; br_taken = 0;
    br_target = '0; flush = 0; flush_pc = '0; if_ready = 0;
  endtask

  task automatic reset_checks(input string tag);
    check1({tag, "_inst_req"}, inst_req, 1'b0);
    check32({tag, "_inst_addr"}, inst_addr, RST_PC);
    check1({tag, "_if_valid"}, if_valid, 1'b0);
    check32({tag, "_if_pc"}, if_pc, RST_PC);
    check32({tag, "_if_inst"}, if_inst, 32'd0);
  endtask

  initial begin
    idle_inputs();
    resetn = 0; drv_en = 0; sram_busy = 0; sram_addr = '0;
    p_aok = 100; p_dok = 100; p_rdy = 100; p_flush = 0; p_br = 0;
    force_flush_wait = 0; force_br_hold = 0; force_flush_br = 0;
    stall_req = 0; stall_left = 0; force_pc = EXC_PC; force_tgt = 32'hBFC0_0100;
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset_checks("rst");
    @(negedge clk);
    resetn = 1;
    #1;
    check1("first_req", inst_req, 1'b1);
    check32("first_addr", inst_addr, RST_PC);
    drv_en = 1;

    // Back-to-back single-cycle SRAM, decode always ready.
    repeat (30) @(posedge clk);

    // Branch while decode holds the branch word.
    p_rdy = 50; force_tgt = 32'hBFC0_0100; force_br_hold = 1;
    repeat (60) @(posedge clk);

    // Redirect while waiting for the returned word.
    p_dok = 30; force_pc = EXC_PC; force_flush_wait = 1;
    repeat (60) @(posedge clk);

    // Redirect and branch in the same cycle.
    p_dok = 100; force_pc = EXC_PC; force_tgt = 32'h8000_0400; force_flush_br = 1;
    repeat (60) @(posedge clk);

    // Decode stalls for 5 cycles.
    p_rdy = 100; stall_req = 1;
    repeat (40) @(posedge clk);

    // Randomized traffic.
    p_aok = 60; p_dok = 50; p_rdy = 60; p_flush = 30; p_br = 15;
    repeat (3000) @(posedge clk);

    // Reset while a word is in flight, then a late data_ok.
    p_flush = 0; p_br = 0; p_aok = 100; p_dok = 0;
    for (int i = 0; i < 50 && !sram_busy; i++) @(posedge clk);
    check1("reached_wait", sram_busy, 1'b1);
    drv_en = 0;
    @(negedge clk);
    idle_inputs();
    resetn = 0;
    model_reset();
    #1 reset_checks("mid_rst");
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    inst_data_ok = sram_busy;
    inst_rdata   = mem_word(sram_addr);
    #1;
    check1("late_req", inst_req, 1'b1);
    check32("late_addr", inst_addr, RST_PC);
    check1("late_valid0", if_valid, 1'b0);
    @(negedge clk);
    inst_data_ok = 0;
    sram_busy    = 0;
    #1 check1("late_valid1", if_valid, 1'b0);
    p_aok = 100; p_dok = 100; p_rdy = 100;
    drv_en = 1;
    repeat (40) @(posedge clk);

    check1("applied_flush_wait", force_flush_wait, 1'b0);
    check1("applied_br_hold", force_br_hold, 1'b0);
    check1("applied_flush_br", force_flush_br, 1'b0);
    check1("applied_stall", stall_req, 1'b0);
    check1("progress", n_consumed > 100, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
